divider: RTL and testbench
==========================

# divider

Sequential 32-bit signed integer divider for the CPU's execute stage, the inverse-operation counterpart of the multi-cycle multiplier. A one-cycle `ctrl_DIV` pulse captures the operands. The unit runs a fixed-latency restoring shift/subtract on magnitudes and applies sign correction. It then presents quotient, remainder and a divide-by-zero flag with a one-cycle `data_resultRDY` pulse that the pipeline stall logic waits on.

## Interface
- No parameters; width fixed at 32.
- `clock` input 1: single clock, all state updates on rising edge.
- `ctrl_resetn` input 1: asynchronous, active-low reset.
- `dividend` input 32: two's-complement numerator, sampled only on a start edge.
- `divisor` input 32: two's-complement denominator, sampled only on a start edge.
- `ctrl_DIV` input 1: start strobe, sampled on rising edge.
- `data_result` output 32: signed quotient, registered.
- `data_remainder` output 32: signed remainder, registered.
- `data_exception` output 1: divide-by-zero flag for the current result.
- `data_resultRDY` output 1: one-cycle completion pulse.

## Operation
- States: IDLE, RUN, FIX, DONE.
- Start edge (ctrl_DIV=1), from any state:
  - latch sign_q = dividend[31]^divisor[31] and sign_r = dividend[31].
  - latch |dividend| into Q, |divisor| into 33-bit D; clear 33-bit R; count=0.
  - latch dz = (divisor==0); go to RUN.
  - A start in RUN/FIX/DONE aborts the current operation without a completion pulse.
- RUN, per edge: shift {R,Q} left 1; T = R - D (33-bit). If T >= 0, R=T and Q[0]=1. count++. After count reaches 32, go to FIX.
- FIX edge:
  - data_result = sign_q ? -Q : Q.
  - data_remainder = sign_r ? -R[31:0] : R[31:0].
  - data_exception = dz; data_resultRDY = 1; go to DONE.
- DONE edge: data_resultRDY = 0; go to IDLE. Outputs hold until the next FIX or reset.
- Arithmetic:
  - Quotient truncates toward zero; remainder takes the dividend's sign, with |rem| < |divisor|.
  - |0x80000000| = 0x80000000 is handled as unsigned magnitude.
  - 0x80000000 / -1 gives quotient 0x80000000 (wrap), remainder 0, data_exception 0.
- Divide by zero: full latency, data_result=0, data_remainder=0, data_exception=1. The iteration result is discarded.
- data_exception is cleared at the next start edge and stays 0 until that operation's FIX.

## Timing
- Reset (ctrl_resetn=0, asynchronous): state IDLE, count 0, data_result 0, data_remainder 0, data_exception 0, data_resultRDY 0.
- Reset mid-operation discards the operation with no pulse. The first start edge after release behaves normally.
- Start edge = edge 0. RUN iterations occur on edges 1..32, and FIX on edge 33.
- data_resultRDY is high from edge 33 to edge 34, exactly one cycle; latency is 33 cycles.
- The earliest back-to-back start is the edge-34 start, concurrent with DONE→IDLE. A start at edge 33 aborts the pulse: the start wins over FIX.
- Operand inputs are don't-care except at start edges.
- ctrl_DIV held high restarts every cycle, so no result is produced.

## Test plan
- 7 / 2 at edge 0 → at edge 33, result 3, remainder 1, exception 0, RDY high exactly 1 cycle.
- -7 / 2 → -3 / -1; 7 / -2 → -3 / 1; -7 / -2 → 3 / -1; 0 / 5 → 0 / 0.
- 0x80000000 / -1 → 0x80000000 / 0, exception 0. 0x80000000 / 1 → 0x80000000 / 0. 0x7FFFFFFF / 0x7FFFFFFF → 1 / 0.
- 123 / 0 → result 0, remainder 0, exception 1 at edge 33. A following 10 / 3 → 3 / 1 with exception cleared.
- 100 / 7 started, then 50 / 5 restarted at edge 10 → no pulse at edge 33. Pulse at edge 43 with 10 / 0.
- Assert ctrl_resetn low at edge 20 of an operation → all outputs 0 immediately and no pulse. A fresh start then yields the correct result after 33 cycles.

Source files
------------

// File: rtl/divider_if.sv
// Operand/start and result/ready bundle for the execute-stage divider.
interface divider_if;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output dividend, divisor, ctrl_DIV,
    input  data_result, data_remainder, data_exception, data_resultRDY
  );

  modport slave (
    input  dividend, divisor, ctrl_DIV,
    output data_result, data_remainder, data_exception, data_resultRDY
  );
endinterface

// File: rtl/divider.sv
// 32-bit signed restoring divider: 32 shift/subtract steps on magnitudes,
// one sign-fix step, then a single-cycle ready pulse.
module divider (
  input  logic     clock,
  input  logic     ctrl_resetn,
  divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] q;
  logic [31:0] r;
  logic [32:0] d;
  logic [5:0]  count;
  logic        sign_q, sign_r, dz;
  logic [31:0] dividend_mag, divisor_mag;
  logic [32:0] t;

  always_comb begin
    dividend_mag = bus.dividend[31] ? (~bus.dividend + 32'd1) : bus.dividend;
    divisor_mag  = bus.divisor[31]  ? (~bus.divisor  + 32'd1) : bus.divisor;
    t            = {r, q[31]} - d;
  end

  always_ff @(posedge clock or negedge ctrl_resetn) begin
    if (!ctrl_resetn) state <= IDLE;
    else              state <= state_next;
  end

  // A start strobe overrides every state, including FIX, so it aborts any pulse.
  always_comb begin
    state_next = state;
    if (bus.ctrl_DIV) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN:     if (count == 6'd31) state_next = FIX;
        FIX:     state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Remainder only needs 32 bits: a kept difference is always below |divisor|.
  always_ff @(posedge clock or negedge ctrl_resetn) begin
    if (!ctrl_resetn) begin
      q      <= '0;
      r      <= '0;
      d      <= '0;
      count  <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dz     <= 1'b0;
    end else if (bus.ctrl_DIV) begin
      q      <= dividend_mag;
      r      <= '0;
      d      <= {1'b0, divisor_mag};
      count  <= '0;
      sign_q <= bus.dividend[31] ^ bus.divisor[31];
      sign_r <= bus.dividend[31];
      dz     <= (bus.divisor == 32'd0);
    end else if (state == RUN) begin
      count <= count + 6'd1;
      if (!t[32]) begin
        r <= t[31:0];
        q <= {q[30:0], 1'b1};
      end else begin
        r <= {r[30:0], q[31]};
        q <= {q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock or negedge ctrl_resetn) begin
    if (!ctrl_resetn) begin
      bus.data_result    <= '0;
      bus.data_remainder <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
    end else if (bus.ctrl_DIV) begin
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
    end else begin
      bus.data_resultRDY <= (state == FIX);
      if (state == FIX) begin
        bus.data_exception <= dz;
        if (dz) begin
          bus.data_result    <= '0;
          bus.data_remainder <= '0;
        end else begin
          bus.data_result    <= sign_q ? (~q + 32'd1) : q;
          bus.data_remainder <= sign_r ? (~r + 32'd1) : r;
        end
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for the signed divider: latency, sign rules, corner
// operands, divide-by-zero, restart/abort and asynchronous reset.
module tb_divider;

  logic clock;
  logic ctrl_resetn;
  int   vectors;
  int   miscompares;
  logic [31:0] last_result;

  divider_if bus ();

  divider dut (
    .clock       (clock),
    .ctrl_resetn (ctrl_resetn),
    .bus         (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive a start strobe so that it is sampled on the next rising edge (edge 0).
  task automatic startOp(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.dividend = a;
    bus.divisor  = b;
    bus.ctrl_DIV = 1'b1;
    @(posedge clock);
    #1;
    bus.ctrl_DIV = 1'b0;
    bus.dividend = 32'hDEAD_BEEF;
    bus.divisor  = 32'h0BAD_F00D;
  endtask

  task automatic countPulses(input int edges, output int pulses);
    pulses = 0;
    for (int i = 0; i < edges; i++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) pulses++;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_q, input logic [31:0] exp_r,
                               input logic exp_ex);
    int pulses;
    startOp(a, b);
    checkOutput({tag, " ex_clear_at_start"}, {31'd0, bus.data_exception}, 32'd0);
    checkOutput({tag, " result_held"}, bus.data_result, last_result);
    countPulses(32, pulses);
    checkOutput({tag, " early_pulse"}, pulses, 32'd0);
    @(posedge clock);
    #1;
    checkOutput({tag, " rdy_e33"}, {31'd0, bus.data_resultRDY}, 32'd1);
    checkOutput({tag, " quotient"}, bus.data_result, exp_q);
    checkOutput({tag, " remainder"}, bus.data_remainder, exp_r);
    checkOutput({tag, " exception"}, {31'd0, bus.data_exception}, {31'd0, exp_ex});
    @(posedge clock);
    #1;
    checkOutput({tag, " rdy_e34"}, {31'd0, bus.data_resultRDY}, 32'd0);
    checkOutput({tag, " quotient_hold"}, bus.data_result, exp_q);
    last_result = exp_q;
  endtask

  initial begin
    int pulses;
    vectors      = 0;
    miscompares  = 0;
    last_result  = 32'd0;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;
    bus.ctrl_DIV = 1'b0;
    ctrl_resetn  = 1'b0;
    #12;
    checkOutput("reset result", bus.data_result, 32'd0);
    checkOutput("reset remainder", bus.data_remainder, 32'd0);
    checkOutput("reset exception", {31'd0, bus.data_exception}, 32'd0);
    checkOutput("reset rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    @(negedge clock);
    ctrl_resetn = 1'b1;

    applyStimulus("7/2",   32'd7,          32'd2,          32'd3,          32'd1,          1'b0);
    applyStimulus("-7/2",  -32'sd7,        32'd2,          -32'sd3,        -32'sd1,        1'b0);
    applyStimulus("7/-2",  32'd7,          -32'sd2,        -32'sd3,        32'd1,          1'b0);
    applyStimulus("-7/-2", -32'sd7,        -32'sd2,        32'd3,          -32'sd1,        1'b0);
    applyStimulus("0/5",   32'd0,          32'd5,          32'd0,          32'd0,          1'b0);
    applyStimulus("min/-1", 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);
    applyStimulus("min/1", 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0);
    applyStimulus("max/max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1,          32'd0,          1'b0);
    applyStimulus("1000/-7", 32'd1000,     -32'sd7,        -32'sd142,      32'd6,          1'b0);
    applyStimulus("123/0", 32'd123,        32'd0,          32'd0,          32'd0,          1'b1);
    applyStimulus("10/3",  32'd10,         32'd3,          32'd3,          32'd1,          1'b0);

    // 100/7 restarted at edge 10 by 50/5: the first operation must never pulse.
    startOp(32'd100, 32'd7);
    countPulses(9, pulses);
    checkOutput("restart pre_pulse", pulses, 32'd0);
    applyStimulus("restart 50/5", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

    // A start coinciding with FIX wins: 9/2 never reports, 20/4 does.
    startOp(32'd9, 32'd2);
    countPulses(32, pulses);
    checkOutput("abort_at_fix pre_pulse", pulses, 32'd0);
    applyStimulus("abort_at_fix 20/4", 32'd20, 32'd4, 32'd5, 32'd0, 1'b0);

    // Asynchronous reset at edge 20 clears outputs immediately and kills the pulse.
    startOp(32'd1000, 32'd3);
    countPulses(19, pulses);
    @(posedge clock);
    #2;
    ctrl_resetn = 1'b0;
    #1;
    checkOutput("midreset result", bus.data_result, 32'd0);
    checkOutput("midreset remainder", bus.data_remainder, 32'd0);
    checkOutput("midreset rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    @(negedge clock);
    ctrl_resetn = 1'b1;
    countPulses(40, pulses);
    checkOutput("midreset no_pulse", pulses, 32'd0);
    last_result = 32'd0;
    applyStimulus("post_reset 1000/3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
